// File: rtl/ad80305_att_pulse_responder.sv
// Far end of the AGC attenuator link: counts inc/dec pulses into a saturating 6-bit code
// and writes every change to the step attenuator over a 3-wire serial bus, MSB first.
module ad80305_att_pulse_responder #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_inc_pulse,
    input  logic       i_dec_pulse,
    input  logic       i_clr,
    input  logic [5:0] i_max_att,
    input  logic       i_read_req,
    output logic       o_read_success,
    output logic [5:0] o_read_value,
    output logic [5:0] o_att_code,
    output logic       o_busy,
    output logic       o_ser_clk,
    output logic       o_ser_data,
    output logic       o_ser_le
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    logic [5:0] code;
    logic [5:0] code_next;
    logic [5:0] shadow;
    logic [5:0] sent;
    logic [4:0] shift_reg;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic       clk_high;
    logic       read_pend;

    // NOTE: code_next gets its default on the first line so no path leaves it unassigned (no latch).
    always_comb begin
        code_next = code;
        if (i_clr)
            code_next = 6'd0;
        else if (i_inc_pulse && !i_dec_pulse)
            code_next = (code >= i_max_att) ? i_max_att : code + 6'd1;
        else if (i_dec_pulse && !i_inc_pulse)
            code_next = (code == 6'd0) ? 6'd0 : code - 6'd1;
        if (code_next > i_max_att)
            code_next = i_max_att;
    end

    // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            code           <= 6'd0;
            shadow         <= 6'd0;
            sent           <= 6'd0;
            shift_reg      <= 5'd0;
            div_cnt        <= 8'd0;
            bit_cnt        <= 3'd0;
            clk_high       <= 1'b0;
            read_pend      <= 1'b0;
            o_read_success <= 1'b0;
            o_read_value   <= 6'd0;
            o_busy         <= 1'b0;
            o_ser_clk      <= 1'b0;
            o_ser_data     <= 1'b0;
            o_ser_le       <= 1'b0;
        end else begin
            code           <= code_next;
            o_read_success <= 1'b0;

            // A request arriving while one is pending merges into the same acknowledge.
            if (state == IDLE && read_pend) begin
                o_read_success <= 1'b1;
                o_read_value   <= shadow;
                read_pend      <= 1'b0;
            end else if (i_read_req) begin
                read_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (code != shadow) begin
                        state  <= LOAD;
                        o_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    // MSB goes straight to the pin; only the remaining five bits are kept.
                    sent       <= code;
                    shift_reg  <= code[4:0];
                    o_ser_data <= code[5];
                    o_ser_clk  <= 1'b0;
                    div_cnt    <= 8'd0;
                    bit_cnt    <= 3'd0;
                    clk_high   <= 1'b0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'd0;
                        if (!clk_high) begin
                            clk_high  <= 1'b1;
                            o_ser_clk <= 1'b1;
                        end else if (bit_cnt == 3'd5) begin
                            clk_high   <= 1'b0;
                            o_ser_clk  <= 1'b0;
                            o_ser_data <= 1'b0;
                            o_ser_le   <= 1'b1;
                            state      <= LATCH;
                        end else begin
                            clk_high   <= 1'b0;
                            o_ser_clk  <= 1'b0;
                            bit_cnt    <= bit_cnt + 3'd1;
                            o_ser_data <= shift_reg[4];
                            shift_reg  <= {shift_reg[3:0], 1'b0};
                        end
                    end
                end
                LATCH: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt  <= 8'd0;
                        o_ser_le <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    shadow <= sent;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign o_att_code = code;

endmodule

// File: tb/tb_ad80305_att_pulse_responder.sv
// Bench for ad80305_att_pulse_responder: directed scenarios plus random pulses, every
// output compared each cycle against a write-timeline model of the attenuator link.
module tb_ad80305_att_pulse_responder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inc_pulse = 1'b0;
    logic       dec_pulse = 1'b0;
    logic       clr = 1'b0;
    logic [5:0] max_att = 6'd63;
    logic       read_req = 1'b0;
    logic       read_success;
    logic [5:0] read_value;
    logic [5:0] att_code;
    logic       busy;
    logic       ser_clk;
    logic       ser_data;
    logic       ser_le;

    ad80305_att_pulse_responder #(.CLK_DIV(D)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_inc_pulse    (inc_pulse),
        .i_dec_pulse    (dec_pulse),
        .i_clr          (clr),
        .i_max_att      (max_att),
        .i_read_req     (read_req),
        .o_read_success (read_success),
        .o_read_value   (read_value),
        .o_att_code     (att_code),
        .o_busy         (busy),
        .o_ser_clk      (ser_clk),
        .o_ser_data     (ser_data),
        .o_ser_le       (ser_le)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: m_pos is -1 when idle, otherwise the cycle index inside a 13*D+2 cycle write.
    int m_code = 0, m_shadow = 0, m_sent = 0, m_pos = -1, m_val = 0;
    bit m_pend = 0, m_succ = 0;

    int last_read = 0;
    int busy_cycles = 0;

    logic [5:0] rx_shift = 6'd0;
    logic [5:0] rx_word = 6'd0;
    int le_count = 0;

    always @(posedge ser_clk) rx_shift <= {rx_shift[4:0], ser_data};
    always @(posedge ser_le) begin
        rx_word  <= rx_shift;
        le_count <= le_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int n;
        bit idle;
        if (rst) begin
            m_code = 0; m_shadow = 0; m_sent = 0; m_pos = -1;
            m_pend = 0; m_succ = 0; m_val = 0;
            return;
        end
        idle = (m_pos < 0);
        n = m_code;
        if (clr) n = 0;
        else if (inc_pulse && !dec_pulse) n = m_code + 1;
        else if (dec_pulse && !inc_pulse) n = (m_code > 0) ? m_code - 1 : 0;
        if (n > int'(max_att)) n = int'(max_att);

        m_succ = idle && m_pend;
        if (m_succ) m_val = m_shadow;
        if (m_succ) m_pend = 0;
        else if (read_req) m_pend = 1;

        if (idle) m_pos = (m_code != m_shadow) ? 0 : -1;
        else if (m_pos == 0) begin m_sent = m_code; m_pos = 1; end
        else if (m_pos == 13*D + 1) begin m_shadow = m_sent; m_pos = -1; end
        else m_pos++;
        m_code = n;
    endtask

    task automatic compare();
        int k;
        bit e_data, e_clk, e_le;
        e_data = 0; e_clk = 0; e_le = 0;
        if (m_pos >= 1 && m_pos <= 12*D) begin
            k = m_pos - 1;
            e_data = ((m_sent >> (5 - k / (2*D))) & 1) != 0;
            e_clk  = (k % (2*D)) >= D;
        end
        if (m_pos > 12*D && m_pos <= 13*D) e_le = 1;
        check("att_code", att_code, m_code);
        check("busy", busy, m_pos >= 0);
        check("ser_data", ser_data, e_data);
        check("ser_clk", ser_clk, e_clk);
        check("ser_le", ser_le, e_le);
        check("read_success", read_success, m_succ);
        check("read_value", read_value, m_val);
        if (read_success) last_read = read_value;
        if (busy) busy_cycles++;
    endtask

    task automatic tick(input logic a_inc, input logic a_dec, input logic a_clr,
                        input logic a_req, input logic a_rst);
        inc_pulse = a_inc; dec_pulse = a_dec; clr = a_clr; read_req = a_req; rst = a_rst;
        @(posedge clk);
        model_edge();
        #1;
        compare();
        inc_pulse = 0; dec_pulse = 0; clr = 0; read_req = 0; rst = 0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    // Runs until no write is in flight and none is owed; an expired budget counts as a failure.
    task automatic wait_idle();
        int n = 0;
        idle_ticks(2);
        while (n < 400 && (busy || m_code != m_shadow)) begin
            tick(0, 0, 0, 0, 0);
            n++;
        end
        if (n >= 400) check("wait_idle_timeout", 1, 0);
    endtask

    initial begin
        int le_snap;

        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        check("reset_code", att_code, 0);
        check("reset_ser_le", ser_le, 0);
        idle_ticks(4);

        // Single increment: one 54-cycle write of 000001, then read back.
        busy_cycles = 0;
        tick(1, 0, 0, 0, 0);
        wait_idle();
        check("busy_len", busy_cycles, 54);
        check("word_inc1", rx_word, 1);
        tick(0, 0, 0, 1, 0);
        idle_ticks(2);
        check("read_inc1", last_read, 1);

        // Saturation at the top and at zero.
        for (int i = 0; i < 63; i++) tick(1, 0, 0, 0, 0);
        wait_idle();
        check("code_63", att_code, 63);
        tick(1, 0, 0, 0, 0);
        idle_ticks(2);
        check("sat_hi_no_write", busy, 0);
        check("sat_hi_code", att_code, 63);
        tick(0, 0, 1, 0, 0);
        wait_idle();
        tick(0, 1, 0, 0, 0);
        idle_ticks(2);
        check("sat_lo_no_write", busy, 0);

        // Write of 5 with three increments and a read landing mid-write.
        for (int i = 0; i < 6; i++) tick(1, 0, 0, 0, 0);
        wait_idle();
        tick(0, 1, 0, 0, 0);
        idle_ticks(6);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        last_read = 99;
        while (busy) tick(0, 0, 0, 0, 0);
        check("word_5", rx_word, 5);
        tick(0, 0, 0, 0, 0);
        check("read_mid_5", last_read, 5);
        check("second_write", busy, 1);
        wait_idle();
        check("word_8", rx_word, 8);
        tick(0, 0, 0, 1, 0);
        idle_ticks(2);
        check("read_8", last_read, 8);

        // Simultaneous inc/dec, then clear beating an increment at code 10.
        tick(1, 1, 0, 0, 0);
        check("inc_dec_same", att_code, 8);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        wait_idle();
        tick(1, 0, 1, 0, 0);
        check("clr_wins", att_code, 0);
        wait_idle();
        check("word_clr", rx_word, 0);

        // Lowering the limit below the current code.
        for (int i = 0; i < 40; i++) tick(1, 0, 0, 0, 0);
        wait_idle();
        max_att = 6'd20;
        tick(0, 0, 0, 0, 0);
        check("clamp_20", att_code, 20);
        wait_idle();
        check("word_20", rx_word, 20);

        // Reset in the middle of the shift phase.
        max_att = 6'd63;
        tick(1, 0, 0, 0, 0);
        idle_ticks(10);
        le_snap = le_count;
        tick(0, 0, 0, 0, 1);
        check("rst_busy", busy, 0);
        check("rst_ser_clk", ser_clk, 0);
        idle_ticks(70);
        check("rst_no_le", le_count, le_snap);
        last_read = 99;
        tick(0, 0, 0, 1, 0);
        idle_ticks(2);
        check("rst_read_0", last_read, 0);

        // Random pulses, limits and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) max_att = 6'($urandom_range(0, 63));
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 999) == 0);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
